// File: rtl/cache_l2_fa_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_l2_fa_responder_pkg
// Purpose  : Shared constants, FSM state encoding and address field helpers
//            for the fully associative L2 responder (also used by L1).
// Contents : ADDR_W / DATA_W / LINES widths, derived index/tag widths,
//            state_t encoding, addr_tag() / addr_off() slice helpers.
// Revision : 1.0 - initial release
// ============================================================================
package cache_l2_fa_responder_pkg;

  localparam int ADDR_W = 7;                  // word address width
  localparam int DATA_W = 17;                 // word width
  localparam int LINES  = 8;                  // fully associative entries
  localparam int IDX_W  = $clog2(LINES);      // line index / age width
  localparam int TAG_W  = ADDR_W - 1;         // two words per line

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MEM_WR = 3'd2,
    ST_FILL0  = 3'd3,
    ST_FILL1  = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  // Line tag is everything above the word offset.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:1];
  endfunction

  // Word offset within a two-word line.
  function automatic logic addr_off(input logic [ADDR_W-1:0] addr);
    return addr[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_l2_fa_responder_lru_age.sv
`default_nettype none
// ============================================================================
// Module   : l2_lru_age
// Purpose  : True-LRU bookkeeping for the L2 via one age counter per line.
//            Age 0 is most recently used, LINES-1 least recently used.
// Ports    : clk, reset       - clock, asynchronous active-high reset
//            i_touch          - mark i_touch_idx as most recently used
//            i_touch_idx      - line being touched
//            o_victim_idx     - line whose age is LINES-1
// Revision : 1.0 - initial release
// ============================================================================
module l2_lru_age
  import cache_l2_fa_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_touch,
  input  logic [IDX_W-1:0] i_touch_idx,
  output logic [IDX_W-1:0] o_victim_idx
);

  logic [IDX_W-1:0] r_age [LINES];
  logic [IDX_W-1:0] w_ref_age;
  logic [IDX_W-1:0] w_victim;

  assign w_ref_age = r_age[i_touch_idx];

  // Only lines younger than the touched one age, so the set of ages stays a
  // permutation of 0..LINES-1 at all times.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        r_age[i] <= IDX_W'(i);
      end
    end else if (i_touch) begin
      for (int i = 0; i < LINES; i++) begin
        if (IDX_W'(i) == i_touch_idx) begin
          r_age[i] <= '0;
        end else if (r_age[i] < w_ref_age) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_victim = '0;
    for (int i = 0; i < LINES; i++) begin
      if (r_age[i] == IDX_W'(LINES - 1)) begin
        w_victim = IDX_W'(i);
      end
    end
  end

  assign o_victim_idx = w_victim;

endmodule
`default_nettype wire

// File: rtl/cache_l2_fa_responder.sv
`default_nettype none
// ============================================================================
// Module   : cache_l2_fa_responder
// Purpose  : 8-line fully associative, 2-word/line, write-through,
//            no-write-allocate L2 servicing one L1 request at a time.
// Ports    : clk, reset                 - clock, async active-high reset
//            i_req_valid/o_req_ready    - L1 request handshake
//            i_req_wren/addr/data       - request type, word address, data
//            o_resp_valid/data/hit      - one-cycle completion pulse
//            o_mem_req/wren/addr/wdata  - memory request, held until ack
//            i_mem_ack/i_mem_rdata      - memory completion / read data
// Revision : 1.0 - initial release
// ============================================================================
module cache_l2_fa_responder
  import cache_l2_fa_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wren,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_resp_hit,
  output logic              o_mem_req,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_t              r_state;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_hit;       // lookup result, reported on write completion
  logic [IDX_W-1:0]    r_line;      // line being refilled

  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag   [LINES];
  logic [DATA_W-1:0]   r_word0 [LINES];
  logic [DATA_W-1:0]   r_word1 [LINES];

  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_resp_hit;
  logic                r_mem_req;
  logic                r_mem_wren;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic [LINES-1:0]    w_match;
  logic                w_hit;
  logic [IDX_W-1:0]    w_hit_idx;
  logic                w_any_free;
  logic [IDX_W-1:0]    w_first_free;
  logic [IDX_W-1:0]    w_lru_victim;
  logic [IDX_W-1:0]    w_alloc_idx;
  logic [DATA_W-1:0]   w_hit_word;
  logic                w_touch;
  logic [IDX_W-1:0]    w_touch_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_off;

  assign w_tag = addr_tag(r_addr);
  assign w_off = addr_off(r_addr);

  // --------------------------------------------------------------------------
  // Parallel tag compare and victim selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_match = '0;
    for (int i = 0; i < LINES; i++) begin
      w_match[i] = r_valid[i] && (r_tag[i] == w_tag);
    end
  end

  assign w_hit = |w_match;

  always_comb begin
    w_hit_idx = '0;
    for (int i = 0; i < LINES; i++) begin
      if (w_match[i]) begin
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  // Scan downward so the lowest-index invalid line wins.
  always_comb begin
    w_any_free   = 1'b0;
    w_first_free = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_any_free   = 1'b1;
        w_first_free = IDX_W'(i);
      end
    end
  end

  assign w_alloc_idx = w_any_free ? w_first_free : w_lru_victim;
  assign w_hit_word  = w_off ? r_word1[w_hit_idx] : r_word0[w_hit_idx];

  // Hits (read or write) and completed refills make the line most recent.
  assign w_touch     = ((r_state == ST_LOOKUP) && w_hit) ||
                       ((r_state == ST_FILL1) && i_mem_ack);
  assign w_touch_idx = (r_state == ST_FILL1) ? r_line : w_hit_idx;

  l2_lru_age u_lru (
    .clk          (clk),
    .reset        (reset),
    .i_touch      (w_touch),
    .i_touch_idx  (w_touch_idx),
    .o_victim_idx (w_lru_victim)
  );

  // --------------------------------------------------------------------------
  // Tag and data storage; no reset needed since r_valid qualifies every entry
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((r_state == ST_LOOKUP) && r_wren && w_hit) begin
      if (w_off) begin
        r_word1[w_hit_idx] <= r_wdata;
      end else begin
        r_word0[w_hit_idx] <= r_wdata;
      end
    end
    if ((r_state == ST_FILL0) && i_mem_ack) begin
      r_word0[r_line] <= i_mem_rdata;
    end
    if ((r_state == ST_FILL1) && i_mem_ack) begin
      r_word1[r_line] <= i_mem_rdata;
      r_tag[r_line]   <= w_tag;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_valid      <= '0;
      r_wren       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_hit        <= 1'b0;
      r_line       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_hit   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_wren   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_wren  <= i_req_wren;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_data;
            r_state <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          r_hit <= w_hit;
          if (r_wren) begin
            // Write-through regardless of hit; a miss does not allocate.
            r_mem_req   <= 1'b1;
            r_mem_wren  <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            r_state     <= ST_MEM_WR;
          end else if (w_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_hit_word;
            r_resp_hit   <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_line     <= w_alloc_idx;
            r_mem_req  <= 1'b1;
            r_mem_wren <= 1'b0;
            r_mem_addr <= {w_tag, 1'b0};
            r_state    <= ST_FILL0;
          end
        end

        ST_MEM_WR: begin
          if (i_mem_ack) begin
            r_mem_req    <= 1'b0;
            r_mem_wren   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= r_wdata;
            r_resp_hit   <= r_hit;
            r_state      <= ST_RESP;
          end
        end

        ST_FILL0: begin
          // mem_req stays asserted; only the address moves to word 1.
          if (i_mem_ack) begin
            r_mem_addr <= {w_tag, 1'b1};
            r_state    <= ST_FILL1;
          end
        end

        ST_FILL1: begin
          if (i_mem_ack) begin
            r_mem_req       <= 1'b0;
            r_valid[r_line] <= 1'b1;
            r_resp_valid    <= 1'b1;
            r_resp_data     <= w_off ? i_mem_rdata : r_word0[r_line];
            r_resp_hit      <= 1'b0;
            r_state         <= ST_RESP;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // A correctly maintained tag store never holds the same tag twice.
  always @(posedge clk) begin
    if (!reset && (r_state == ST_LOOKUP)) begin
      assert ($onehot0(w_match));
    end
  end

  assign o_req_ready  = (r_state == ST_IDLE) && !reset;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_hit   = r_resp_hit;
  assign o_mem_req    = r_mem_req;
  assign o_mem_wren   = r_mem_wren;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_l2_fa_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_l2_fa_responder
// Purpose  : Self-checking bench for cache_l2_fa_responder: directed vector
//            table, randomized traffic against a recency-list reference
//            model, and a reset-during-refill sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_l2_fa_responder;
  import cache_l2_fa_responder_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_wren;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_data;
  logic              o_resp_valid;
  logic [DATA_W-1:0] o_resp_data;
  logic              o_resp_hit;
  logic              o_mem_req;
  logic              o_mem_wren;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;

  always #5 clk = ~clk;

  cache_l2_fa_responder dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_wren   (i_req_wren),
    .i_req_addr   (i_req_addr),
    .i_req_data   (i_req_data),
    .o_resp_valid (o_resp_valid),
    .o_resp_data  (o_resp_data),
    .o_resp_hit   (o_resp_hit),
    .o_mem_req    (o_mem_req),
    .o_mem_wren   (o_mem_wren),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Main memory model with random latency
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem     [1 << ADDR_W];
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  bit                mem_busy    = 1'b0;
  int                mem_wait    = 0;
  bit                hold_fill1  = 1'b0;  // withhold acks for word-1 refills
  bit                spurious_en = 1'b0;
  int                n_rd, n_wr, n_memcyc;
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_addr_last;
  logic [DATA_W-1:0] wr_data_last;

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return DATA_W'((a * 32'h1357 + 32'h5) ^ (a << 11));
  endfunction

  always @(negedge clk) begin
    i_mem_ack   = 1'b0;
    i_mem_rdata = DATA_W'($urandom);
    if (reset) begin
      mem_busy = 1'b0;
    end else if (o_mem_req) begin
      n_memcyc++;
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = int'($urandom_range(0, 2));
      end
      if (mem_wait > 0) begin
        mem_wait--;
      end else if (!(hold_fill1 && !o_mem_wren && o_mem_addr[0])) begin
        i_mem_ack = 1'b1;
        mem_busy  = 1'b0;
        if (o_mem_wren) begin
          mem[o_mem_addr] = o_mem_wdata;
          wr_addr_last    = o_mem_addr;
          wr_data_last    = o_mem_wdata;
          n_wr++;
        end else begin
          i_mem_rdata = mem[o_mem_addr];
          rd_log.push_back(o_mem_addr);
          n_rd++;
        end
      end
    end else if (spurious_en && ($urandom_range(0, 7) == 0)) begin
      i_mem_ack = 1'b1;   // stray ack while no request is pending
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: recency-ordered list of cached line tags (front = MRU)
  // --------------------------------------------------------------------------
  logic [TAG_W-1:0] lru_q[$];

  function automatic void model_access(input bit wren, input logic [ADDR_W-1:0] addr,
                                       input logic [DATA_W-1:0] data,
                                       output logic [DATA_W-1:0] ed, output bit eh,
                                       output int erd, output int ewr);
    int pos;
    logic [TAG_W-1:0] t;
    pos = -1;
    t   = addr[ADDR_W-1:1];
    foreach (lru_q[i]) if (lru_q[i] == t) pos = i;
    eh = (pos >= 0);
    if (wren) begin
      ref_mem[addr] = data;
      ed = data; erd = 0; ewr = 1;
    end else begin
      ed = ref_mem[addr]; erd = eh ? 0 : 2; ewr = 0;
    end
    if (eh) begin
      lru_q.delete(pos);
      lru_q.push_front(t);
    end else if (!wren) begin
      if (lru_q.size() == LINES) void'(lru_q.pop_back());
      lru_q.push_front(t);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic summary_and_finish();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    i_req_valid = 1'b0;
    #1;
    check("reset_outputs",
          {o_resp_valid, o_resp_hit, o_mem_req, o_mem_wren, 1'b0},
          32'h0);
    check("reset_bus", {o_resp_data, o_mem_addr, o_mem_wdata} != 0, 32'h0);
    check("reset_ready_low", o_req_ready, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lru_q.delete();
    #1;
    check("ready_after_reset", o_req_ready, 32'h1);
  endtask

  // Issue one request, wait for its response and check it against expectations.
  task automatic run_req(input string tag, input bit wren, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data,
                         input logic [DATA_W-1:0] ed, input bit eh,
                         input int erd, input int ewr);
    int  lat;
    bit  got;
    logic [DATA_W-1:0] rdata;
    logic              rhit;
    for (int w = 0; w < 20 && !o_req_ready; w++) @(negedge clk);
    n_rd = 0; n_wr = 0; n_memcyc = 0;
    rd_log.delete();
    i_req_valid = 1'b1;
    i_req_wren  = wren;
    i_req_addr  = addr;
    i_req_data  = data;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_req_wren  = 1'($urandom);
    i_req_addr  = ADDR_W'($urandom);
    i_req_data  = DATA_W'($urandom);
    lat = 1;
    got = 1'b0;
    rdata = '0;
    rhit  = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_resp_valid) begin
        got   = 1'b1;
        rdata = o_resp_data;
        rhit  = o_resp_hit;
        break;
      end
      lat++;
    end
    if (!got) begin
      check({tag, "_resp_timeout"}, 32'h0, 32'h1);
      summary_and_finish();
    end
    check({tag, "_data"}, rdata, ed);
    check({tag, "_hit"}, rhit, eh);
    check({tag, "_mem_reads"}, n_rd, erd);
    check({tag, "_mem_writes"}, n_wr, ewr);
    check({tag, "_latency"}, lat, 2 + n_memcyc);
    if (erd == 2 && rd_log.size() == 2) begin
      check({tag, "_fill_addr0"}, rd_log[0], {addr[ADDR_W-1:1], 1'b0});
      check({tag, "_fill_addr1"}, rd_log[1], {addr[ADDR_W-1:1], 1'b1});
    end
    if (ewr == 1) begin
      check({tag, "_wr_addr"}, wr_addr_last, addr);
      check({tag, "_wr_data"}, wr_data_last, data);
    end
    check({tag, "_ready_in_resp"}, o_req_ready, 32'h0);
    @(negedge clk);
    check({tag, "_resp_pulse"}, o_resp_valid, 32'h0);
    check({tag, "_ready_after"}, o_req_ready, 32'h1);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    bit                rst;
    bit                wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp_data;
    bit                exp_hit;
    int                exp_rd;
    int                exp_wr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input bit rst, input bit wren, input int addr, input int data,
                              input int ed, input bit eh, input int erd, input int ewr);
    vec_t v;
    v.rst = rst; v.wren = wren; v.addr = ADDR_W'(addr); v.data = DATA_W'(data);
    v.exp_data = DATA_W'(ed); v.exp_hit = eh; v.exp_rd = erd; v.exp_wr = ewr;
    return v;
  endfunction

  initial begin
    logic [DATA_W-1:0] ed;
    bit                eh;
    int                erd, ewr;
    bit                wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                seen;

    reset = 1'b1;
    i_req_valid = 1'b0;
    i_req_wren  = 1'b0;
    i_req_addr  = '0;
    i_req_data  = '0;
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      mem[a]     = init_word(a);
      ref_mem[a] = init_word(a);
    end
    mem[7'h10] = 17'h000AA; ref_mem[7'h10] = 17'h000AA;
    mem[7'h11] = 17'h000BB; ref_mem[7'h11] = 17'h000BB;

    // Refill, hit, write hit, write miss then refill of the written word.
    vt.push_back(mk(1, 0, 'h10, 0,       'h000AA, 0, 2, 0));
    vt.push_back(mk(0, 0, 'h11, 0,       'h000BB, 1, 0, 0));
    vt.push_back(mk(0, 1, 'h10, 'h1FFFF, 'h1FFFF, 1, 0, 1));
    vt.push_back(mk(0, 0, 'h10, 0,       'h1FFFF, 1, 0, 0));
    vt.push_back(mk(0, 1, 'h40, 'h00123, 'h00123, 0, 0, 1));
    vt.push_back(mk(0, 0, 'h40, 0,       'h00123, 0, 2, 0));
    // Fill all 8 lines, refresh line 0x00, then force an LRU eviction.
    vt.push_back(mk(1, 0, 'h00, 0, int'(init_word('h00)), 0, 2, 0));
    for (int a = 'h02; a <= 'h0E; a += 2)
      vt.push_back(mk(0, 0, a, 0, int'(init_word(a)), 0, 2, 0));
    vt.push_back(mk(0, 0, 'h00, 0, int'(init_word('h00)), 1, 0, 0));
    vt.push_back(mk(0, 0, 'h20, 0, int'(init_word('h20)), 0, 2, 0));
    vt.push_back(mk(0, 0, 'h01, 0, int'(init_word('h01)), 1, 0, 0));
    vt.push_back(mk(0, 0, 'h0F, 0, int'(init_word('h0F)), 1, 0, 0));
    vt.push_back(mk(0, 0, 'h03, 0, int'(init_word('h03)), 0, 2, 0));
    vt.push_back(mk(0, 0, 'h02, 0, int'(init_word('h02)), 1, 0, 0));

    repeat (2) @(negedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) apply_reset();
      model_access(vt[i].wren, vt[i].addr, vt[i].data, ed, eh, erd, ewr);
      run_req($sformatf("vec%0d", i), vt[i].wren, vt[i].addr, vt[i].data,
              vt[i].exp_data, vt[i].exp_hit, vt[i].exp_rd, vt[i].exp_wr);
    end

    // Randomized traffic over 24 lines so evictions happen constantly.
    apply_reset();
    spurious_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      wren = ($urandom_range(0, 3) == 0);
      addr = ADDR_W'($urandom_range(0, 47));
      data = DATA_W'($urandom);
      model_access(wren, addr, data, ed, eh, erd, ewr);
      run_req($sformatf("rnd%0d", i), wren, addr, data, ed, eh, erd, ewr);
    end
    spurious_en = 1'b0;

    // Reset while the second refill word is outstanding.
    model_access(1'b0, 7'h30, '0, ed, eh, erd, ewr);
    run_req("pre_rst", 1'b0, 7'h30, '0, ed, eh, erd, ewr);
    model_access(1'b0, 7'h36, '0, ed, eh, erd, ewr);
    hold_fill1 = 1'b1;
    for (int w = 0; w < 20 && !o_req_ready; w++) @(negedge clk);
    i_req_valid = 1'b1;
    i_req_wren  = 1'b0;
    i_req_addr  = 7'h36;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_mem_req && !o_mem_wren && (o_mem_addr == 7'h37)) begin
        seen = 1'b1;
        break;
      end
    end
    check("fill1_reached", seen, 32'h1);
    reset = 1'b1;
    #1;
    check("midfill_mem_req_drop", o_mem_req, 32'h0);
    check("midfill_ready_low", o_req_ready, 32'h0);
    hold_fill1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lru_q.delete();
    #1;
    check("midfill_ready_after", o_req_ready, 32'h1);
    model_access(1'b0, 7'h36, '0, ed, eh, erd, ewr);
    run_req("reread_36", 1'b0, 7'h36, '0, ed, eh, erd, ewr);
    model_access(1'b0, 7'h30, '0, ed, eh, erd, ewr);
    run_req("reread_30", 1'b0, 7'h30, '0, ed, eh, erd, ewr);
    model_access(1'b0, 7'h37, '0, ed, eh, erd, ewr);
    run_req("reread_37", 1'b0, 7'h37, '0, ed, eh, erd, ewr);

    summary_and_finish();
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got expired expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
